// File: rtl/risc_v_mike_pkg.sv
// Shared definitions for the risc_v_mike load/store unit.
// Contents:
//   RISC_V_MIKE_RST_FF - reset-flop macro. It opens an always_ff with an
//                        asynchronous, active-high reset.
//   t_lsu_state        - LSU FSM states.
//   t_lsu_funct3       - RV32I load funct3 encodings. Stores reuse the
//                        000/001/010 values through the F3_S* aliases.
//   t_lsu_err          - response error codes.
//   funct3_legal()     - reports whether a funct3 is legal for a load or a store.
`ifndef RISC_V_MIKE_RST_FF
`define RISC_V_MIKE_RST_FF(clk_sig, rst_sig) always_ff @(posedge clk_sig or posedge rst_sig)
`endif

package risc_v_mike_pkg;

  localparam int LSU_ERR_W    = 2;
  localparam int LSU_FUNCT3_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } t_lsu_state;

  typedef enum logic [LSU_FUNCT3_W-1:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } t_lsu_funct3;

  // The store encodings are the same as the signed load encodings.
  // They are therefore aliases and not separate enum members.
  localparam t_lsu_funct3 F3_SB = F3_LB;
  localparam t_lsu_funct3 F3_SH = F3_LH;
  localparam t_lsu_funct3 F3_SW = F3_LW;

  typedef enum logic [LSU_ERR_W-1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } t_lsu_err;

  // Stores accept only 000..010.
  // Loads reject 011, 110 and 111.
  function automatic logic funct3_legal(input logic write,
                                        input logic [LSU_FUNCT3_W-1:0] f3);
    if (write) return (f3 <= 3'b010);
    return !((f3 == 3'b011) || (f3[2:1] == 2'b11));
  endfunction

endpackage

// File: rtl/risc_v_mike_lsu_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   funct3     - latched RV32I funct3 of the access
//   addr_lo    - byte offset within the word (addr[1:0])
//   mem_word   - current contents of the addressed memory word
//   store_data - store operand; only the low byte or half is used for SB/SH
//   load_data  - addressed lane, sign- or zero-extended to 32 bits
//   store_word - full word to write back: mem_word with the addressed lane
//                replaced for SB/SH, or store_data for SW
module risc_v_mike_lsu_align
  import risc_v_mike_pkg::*;
(
  input  logic [LSU_FUNCT3_W-1:0] funct3,
  input  logic [1:0]              addr_lo,
  input  logic [31:0]             mem_word,
  input  logic [31:0]             store_data,
  output logic [31:0]             load_data,
  output logic [31:0]             store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = mem_word[7:0];
      2'd1:    lane_b = mem_word[15:8];
      2'd2:    lane_b = mem_word[23:16];
      default: lane_b = mem_word[31:24];
    endcase
    // Alignment has already been checked, so addr[1] alone selects the half.
    lane_h = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      F3_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      F3_LBU:  load_data = {24'd0, lane_b};
      F3_LHU:  load_data = {16'd0, lane_h};
      default: load_data = mem_word;
    endcase
  end

  // Read-modify-write merge. The memory port writes full words only.
  always_comb begin
    store_word = mem_word;
    case (funct3)
      F3_SB: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = store_data[7:0];
          2'd1:    store_word[15:8]  = store_data[7:0];
          2'd2:    store_word[23:16] = store_data[7:0];
          default: store_word[31:24] = store_data[7:0];
        endcase
      end
      F3_SH: begin
        if (addr_lo[1]) store_word[31:16] = store_data[15:0];
        else            store_word[15:0]  = store_data[15:0];
      end
      default: store_word = store_data;
    endcase
  end

endmodule

// File: rtl/risc_v_mike_load_store_unit.sv
// Load/store unit placed in front of a word-addressed, full-word-write data memory.
//
// Each request goes through three steps:
//   1. It is latched in IDLE.
//   2. In ACCESS it is checked and performed against memory (one cycle).
//   3. In RESP the response is held until writeback accepts it.
//
// Handshakes:
//   - Request:  a transfer happens on a rising clk edge where lsu_req_valid
//     and lsu_req_ready are both 1. The requester holds valid and the payload
//     until that edge.
//   - Response: lsu_resp_valid stays high, with rdata/err stable, until the
//     edge where lsu_resp_ready is 1.
//
// Ports:
//   clk, rst               - clock; asynchronous active-high reset
//   lsu_req_*              - request from execute (valid/ready, write, funct3, addr, wdata)
//   lsu_resp_*             - response to writeback (valid/ready, rdata, err)
//   data_mem_addr          - word index into data memory
//   data_mem_write         - full-word write strobe
//   data_mem_wr_data       - word to write
//   data_mem_rd_data       - combinational read of data_mem_addr
//   lsu_state              - current FSM state, for observation
module risc_v_mike_load_store_unit
  import risc_v_mike_pkg::*;
#(
  parameter int DATA_MEM_DEPTH = 16,
  parameter int MEM_ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic                    lsu_req_write,
  input  logic [LSU_FUNCT3_W-1:0] lsu_req_funct3,
  input  logic [31:0]             lsu_req_addr,
  input  logic [31:0]             lsu_req_wdata,
  output logic                    lsu_resp_valid,
  input  logic                    lsu_resp_ready,
  output logic [31:0]             lsu_resp_rdata,
  output logic [LSU_ERR_W-1:0]    lsu_resp_err,
  output logic [MEM_ADDR_W-1:0]   data_mem_addr,
  output logic                    data_mem_write,
  output logic [31:0]             data_mem_wr_data,
  input  logic [31:0]             data_mem_rd_data,
  output t_lsu_state              lsu_state
);

  // Compared against the full 32-bit address.
  // High addresses therefore never alias onto low words.
  localparam logic [31:0] ADDR_LIMIT = 32'(DATA_MEM_DEPTH * 4);

  t_lsu_state              state;
  logic                    lat_write;
  logic [LSU_FUNCT3_W-1:0] lat_funct3;
  logic [31:0]             lat_addr;
  logic [31:0]             lat_wdata;
  logic                    resp_valid_q;
  logic [31:0]             resp_rdata_q;
  t_lsu_err                resp_err_q;

  t_lsu_err                access_err;
  logic [31:0]             load_data;
  logic [31:0]             store_word;
  logic                    mem_write;

  risc_v_mike_lsu_align u_align (
    .funct3     (lat_funct3),
    .addr_lo    (lat_addr[1:0]),
    .mem_word   (data_mem_rd_data),
    .store_data (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Error priority: illegal funct3, then misaligned, then out of range.
  // funct3[1:0] gives the access size for both loads and stores.
  always_comb begin
    access_err = ERR_OK;
    if (!funct3_legal(lat_write, lat_funct3))
      access_err = ERR_ILLEGAL;
    else if (((lat_funct3[1:0] == 2'b01) && lat_addr[0]) ||
             ((lat_funct3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00)))
      access_err = ERR_MISALIGN;
    else if (lat_addr >= ADDR_LIMIT)
      access_err = ERR_RANGE;
  end

  // The write strobe is decoded from the state register.
  // It therefore drops as soon as rst asserts, so an aborted store never lands.
  assign mem_write        = (state == ST_ACCESS) && lat_write && (access_err == ERR_OK);
  assign data_mem_write   = mem_write;
  assign data_mem_wr_data = mem_write ? store_word : 32'd0;
  assign data_mem_addr    = lat_addr[MEM_ADDR_W+1:2];

  assign lsu_req_ready  = (state == ST_IDLE);
  assign lsu_resp_valid = resp_valid_q;
  assign lsu_resp_rdata = resp_rdata_q;
  assign lsu_resp_err   = resp_err_q;
  assign lsu_state      = state;

  `RISC_V_MIKE_RST_FF(clk, rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      lat_write    <= 1'b0;
      lat_funct3   <= '0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lsu_req_valid) begin
            lat_write  <= lsu_req_write;
            lat_funct3 <= lsu_req_funct3;
            lat_addr   <= lsu_req_addr;
            lat_wdata  <= lsu_req_wdata;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          resp_err_q   <= access_err;
          resp_rdata_q <= (lat_write || (access_err != ERR_OK)) ? 32'd0 : load_data;
          resp_valid_q <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (lsu_resp_ready) begin
            resp_valid_q <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_mike_load_store_unit.sv
// Directed bench for risc_v_mike_load_store_unit.
// The data memory is modelled behaviourally next to the DUT.
// A reference memory with plain byte arithmetic predicts every response and every write.
module tb_risc_v_mike_load_store_unit;
  import risc_v_mike_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 5;

  logic              clk;
  logic              rst;
  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_req_write;
  logic [2:0]        lsu_req_funct3;
  logic [31:0]       lsu_req_addr;
  logic [31:0]       lsu_req_wdata;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [31:0]       lsu_resp_rdata;
  logic [1:0]        lsu_resp_err;
  logic [AW-1:0]     data_mem_addr;
  logic              data_mem_write;
  logic [31:0]       data_mem_wr_data;
  logic [31:0]       data_mem_rd_data;
  t_lsu_state        lsu_state;

  risc_v_mike_load_store_unit #(.DATA_MEM_DEPTH(DEPTH), .MEM_ADDR_W(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_req_valid    (lsu_req_valid),
    .lsu_req_ready    (lsu_req_ready),
    .lsu_req_write    (lsu_req_write),
    .lsu_req_funct3   (lsu_req_funct3),
    .lsu_req_addr     (lsu_req_addr),
    .lsu_req_wdata    (lsu_req_wdata),
    .lsu_resp_valid   (lsu_resp_valid),
    .lsu_resp_ready   (lsu_resp_ready),
    .lsu_resp_rdata   (lsu_resp_rdata),
    .lsu_resp_err     (lsu_resp_err),
    .data_mem_addr    (data_mem_addr),
    .data_mem_write   (data_mem_write),
    .data_mem_wr_data (data_mem_wr_data),
    .data_mem_rd_data (data_mem_rd_data),
    .lsu_state        (lsu_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- data memory (environment) ----------------
  logic [31:0] dmem [32];
  int          wr_count;
  logic        mem_clear;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) dmem[i] <= 32'd0;
      wr_count <= 0;
    end else if (data_mem_write) begin
      dmem[data_mem_addr] <= data_mem_wr_data;
      wr_count <= wr_count + 1;
    end
  end

  assign data_mem_rd_data = dmem[data_mem_addr];

  // ---------------- scoreboard ----------------
  int          n_cmp;
  int          n_fail;
  logic [33:0] exp_q[$];      // {err, rdata}
  logic [31:0] ref_mem [DEPTH];
  int          exp_writes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: byte-granular memory plus extension rules.
  function automatic logic [33:0] model(input logic w, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] d);
    int          size;
    int          idx;
    int          off;
    logic        legal;
    logic [1:0]  e;
    logic [31:0] v;
    legal = w ? (f3 <= 3'd2)
              : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = 1 << f3[1:0];
    if (!legal)                              e = 2'b11;
    else if ((a % 32'(size)) != 32'd0)      e = 2'b01;
    else if (a >= 32'(DEPTH * 4))           e = 2'b10;
    else                                     e = 2'b00;
    v = 32'd0;
    if (e == 2'b00) begin
      idx = int'(a >> 2);
      off = int'(a[1:0]);
      if (w) begin
        for (int i = 0; i < size; i++)
          ref_mem[idx][8*(off+i) +: 8] = d[8*i +: 8];
        exp_writes++;
      end else begin
        v = ref_mem[idx] >> (8 * off);
        if (size == 1)      v = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (size == 2) v = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      end
    end
    return {e, v};
  endfunction

  // Compare process: every cycle a response is presented it must match the queue head.
  always @(negedge clk) begin
    if (!rst && lsu_resp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_unexpected: got valid rdata %h err %0d, expected no response",
                 lsu_resp_rdata, lsu_resp_err);
      end else begin
        check("resp_rdata", lsu_resp_rdata, exp_q[0][31:0]);
        check("resp_err", {30'd0, lsu_resp_err}, {30'd0, exp_q[0][33:32]});
        if (lsu_resp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_mem(input string name);
    for (int i = 0; i < DEPTH; i++) check({name, "_mem"}, dmem[i], ref_mem[i]);
    check({name, "_writes"}, 32'(wr_count), 32'(exp_writes));
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge.
  // The task returns just after a rising edge with the DUT back in IDLE.
  task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input int stall,
                        input logic [31:0] lit_rdata, input logic [1:0] lit_err);
    int n;
    lsu_req_valid  = 1'b1;
    lsu_req_write  = w;
    lsu_req_funct3 = f3;
    lsu_req_addr   = a;
    lsu_req_wdata  = d;
    lsu_resp_ready = (stall == 0);
    n = 0;
    @(negedge clk);
    while (!lsu_req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!lsu_req_ready) begin
      check({name, "_accept"}, 32'(lsu_req_ready), 32'd1);
      lsu_req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    exp_q.push_back(model(w, f3, a, d));
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lsu_resp_valid && n < 10);
    check({name, "_latency"}, 32'(n), 32'd2);
    if (!lsu_resp_valid) begin
      void'(exp_q.pop_back());
      lsu_resp_ready = 1'b1;
      @(posedge clk); #1;
      return;
    end
    check({name, "_rdata_lit"}, lsu_resp_rdata, lit_rdata);
    check({name, "_err_lit"}, {30'd0, lsu_resp_err}, {30'd0, lit_err});
    if (stall > 0) begin
      // A competing store request while the response is stalled.
      // It must not be accepted.
      lsu_req_valid  = 1'b1;
      lsu_req_write  = 1'b1;
      lsu_req_funct3 = 3'b010;
      lsu_req_addr   = 32'h0;
      lsu_req_wdata  = 32'hBAD0BAD0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check({name, "_stall_valid"}, 32'(lsu_resp_valid), 32'd1);
        check({name, "_stall_req_ready"}, 32'(lsu_req_ready), 32'd0);
      end
      @(posedge clk); #1;
      lsu_req_valid  = 1'b0;
      lsu_resp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check({name, "_idle_state"}, 32'(lsu_state), 32'(ST_IDLE));
    check({name, "_idle_req_ready"}, 32'(lsu_req_ready), 32'd1);
    check({name, "_idle_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
    check_mem(name);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, 32'(lsu_req_ready), 32'd1);
    check({name, "_resp_valid"}, 32'(lsu_resp_valid), 32'd0);
    check({name, "_resp_rdata"}, lsu_resp_rdata, 32'd0);
    check({name, "_resp_err"}, {30'd0, lsu_resp_err}, 32'd0);
    check({name, "_mem_write"}, 32'(data_mem_write), 32'd0);
    check({name, "_mem_addr"}, 32'(data_mem_addr), 32'd0);
    check({name, "_mem_wr_data"}, data_mem_wr_data, 32'd0);
    check({name, "_state"}, 32'(lsu_state), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    exp_writes     = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    rst            = 1'b1;
    mem_clear      = 1'b1;
    lsu_req_valid  = 1'b0;
    lsu_req_write  = 1'b0;
    lsu_req_funct3 = 3'd0;
    lsu_req_addr   = 32'd0;
    lsu_req_wdata  = 32'd0;
    lsu_resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk); #1;
    rst       = 1'b0;
    mem_clear = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_release");
    @(posedge clk); #1;

    // Word store and load back
    do_req("sw_08",  1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 0, 32'h0,        2'b00);
    do_req("lw_08",  1'b0, 3'b010, 32'h08, 32'h0,        0, 32'hDEADBEEF, 2'b00);

    // Byte read-modify-write and extension
    do_req("sw_0c",  1'b1, 3'b010, 32'h0C, 32'h11223344, 0, 32'h0,        2'b00);
    do_req("sb_0d",  1'b1, 3'b000, 32'h0D, 32'hFFFFFFAA, 0, 32'h0,        2'b00);
    check("sb_0d_word3_lit", dmem[3], 32'h1122AA44);
    do_req("lb_0d",  1'b0, 3'b000, 32'h0D, 32'h0,        0, 32'hFFFFFFAA, 2'b00);
    do_req("lbu_0d", 1'b0, 3'b100, 32'h0D, 32'h0,        0, 32'h000000AA, 2'b00);

    // Half-word extension and merge
    do_req("sw_0c2", 1'b1, 3'b010, 32'h0C, 32'h80017FFF, 0, 32'h0,        2'b00);
    do_req("lh_0e",  1'b0, 3'b001, 32'h0E, 32'h0,        0, 32'hFFFF8001, 2'b00);
    do_req("lhu_0e", 1'b0, 3'b101, 32'h0E, 32'h0,        0, 32'h00008001, 2'b00);
    do_req("sh_0c",  1'b1, 3'b001, 32'h0C, 32'hFFFF1234, 0, 32'h0,        2'b00);
    check("sh_0c_word3_lit", dmem[3], 32'h80011234);

    // Error responses; memory must stay unchanged
    do_req("lw_06",     1'b0, 3'b010, 32'h06, 32'h0,        0, 32'h0, 2'b01);
    do_req("sw_40",     1'b1, 3'b010, 32'h40, 32'h12345678, 0, 32'h0, 2'b10);
    do_req("ld_f3_011", 1'b0, 3'b011, 32'h08, 32'h0,        0, 32'h0, 2'b11);
    do_req("st_f3_011", 1'b1, 3'b011, 32'h08, 32'h55555555, 0, 32'h0, 2'b11);
    do_req("sh_05",     1'b1, 3'b001, 32'h05, 32'h0000FFFF, 0, 32'h0, 2'b01);
    do_req("lw_41",     1'b0, 3'b010, 32'h41, 32'h0,        0, 32'h0, 2'b01);
    do_req("ld_f3_111", 1'b0, 3'b111, 32'h41, 32'h0,        0, 32'h0, 2'b11);
    do_req("sw_80",     1'b1, 3'b010, 32'h80, 32'hCCCCCCCC, 0, 32'h0, 2'b10);
    do_req("lb_40",     1'b0, 3'b000, 32'h40, 32'h0,        0, 32'h0, 2'b10);

    // Last legal byte address
    do_req("sw_3c",  1'b1, 3'b010, 32'h3C, 32'hA5000000, 0, 32'h0,        2'b00);
    do_req("lb_3f",  1'b0, 3'b000, 32'h3F, 32'h0,        0, 32'hFFFFFFA5, 2'b00);
    do_req("sb_3f",  1'b1, 3'b000, 32'h3F, 32'h0000005A, 0, 32'h0,        2'b00);
    check("sb_3f_word15_lit", dmem[15], 32'h5A000000);
    do_req("lbu_3f", 1'b0, 3'b100, 32'h3F, 32'h0,        0, 32'h0000005A, 2'b00);

    // Writeback back-pressure
    do_req("lw_08_stall", 1'b0, 3'b010, 32'h08, 32'h0, 5, 32'hDEADBEEF, 2'b00);

    // Reset in the middle of an access
    do_req("sw_04", 1'b1, 3'b010, 32'h04, 32'h01010101, 0, 32'h0, 2'b00);
    lsu_req_valid  = 1'b1;
    lsu_req_write  = 1'b1;
    lsu_req_funct3 = 3'b010;
    lsu_req_addr   = 32'h04;
    lsu_req_wdata  = 32'hCAFEF00D;
    @(negedge clk);
    check("rstmid_req_ready", 32'(lsu_req_ready), 32'd1);
    @(posedge clk); #1;
    check("rstmid_in_access", 32'(lsu_state), 32'(ST_ACCESS));
    rst           = 1'b1;
    lsu_req_valid = 1'b0;
    #1;
    check("rstmid_async_write", 32'(data_mem_write), 32'd0);
    @(negedge clk);
    check_reset_outputs("rstmid_hold");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rstmid_release");
    check("rstmid_word1_lit", dmem[1], 32'h01010101);
    check_mem("rstmid");
    @(posedge clk); #1;
    do_req("lw_04_after_rst", 1'b0, 3'b010, 32'h04, 32'h0, 0, 32'h01010101, 2'b00);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
